// File: rtl/vend_ctrl_fsm_pkg.sv
// Shared definitions for the vending controller: state codes, money width,
// balance limit and a small state-class helper.
package vend_pkg;

    localparam int VAL_W = 11;
    localparam logic [VAL_W-1:0] MAX_BAL = 11'd1999;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_PAY_CHK = 3'd2;
    localparam logic [2:0] ST_PAY_DO  = 3'd3;
    localparam logic [2:0] ST_DISP    = 3'd4;
    localparam logic [2:0] ST_WARN    = 3'd5;
    localparam logic [2:0] ST_CHARGE  = 3'd6;

    typedef logic [VAL_W-1:0] val_t;

    // Coins are only taken while the machine is idle or browsing products.
    function automatic logic coin_state(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_SELECT);
    endfunction

endpackage

// File: rtl/vend_ctrl_fsm_if.sv
// Handshake bundle between the touch/flag driver (master) and the
// vending controller (slave).
interface vend_ctrl_fsm_if;
    import vend_pkg::*;

    logic       select_flag;
    logic       sure_flag;
    logic       cancel_flag;
    logic       coin_sig;
    logic       charge_flag;
    logic       nonenough_flag;
    logic       coin_ov_flag;
    logic [3:0] product_number;
    val_t       coin_val_sum;

    logic       selected_sta_flag;
    logic       coin_sta_flag;
    logic       coin_fn_flag;
    logic       pay_sta_flag;
    logic       pay_st_flag;
    logic       charge_st_flag;
    logic       dispense_flag;
    logic       warn_flag;
    logic       coin_rej_flag;
    logic       charge_busy;
    val_t       change_val;
    logic [2:0] state_o;

    modport slave (
        input  select_flag, sure_flag, cancel_flag, coin_sig, charge_flag,
               nonenough_flag, coin_ov_flag, product_number, coin_val_sum,
        output selected_sta_flag, coin_sta_flag, coin_fn_flag, pay_sta_flag,
               pay_st_flag, charge_st_flag, dispense_flag, warn_flag,
               coin_rej_flag, charge_busy, change_val, state_o
    );

    modport master (
        output select_flag, sure_flag, cancel_flag, coin_sig, charge_flag,
               nonenough_flag, coin_ov_flag, product_number, coin_val_sum,
        input  selected_sta_flag, coin_sta_flag, coin_fn_flag, pay_sta_flag,
               pay_st_flag, charge_st_flag, dispense_flag, warn_flag,
               coin_rej_flag, charge_busy, change_val, state_o
    );

endinterface

// File: rtl/vend_ctrl_fsm_coin_accept.sv
// Coin acceptance: holds a coin pending for COIN_DLY cycles, samples the
// driver's overflow flag one cycle before deciding, then pulses add or reject.
module vend_coin_accept #(
    parameter int COIN_DLY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic coin_sig,
    input  logic coin_en,
    input  logic coin_ov_flag,
    output logic pending,
    output logic coin_take,
    output logic coin_fn_flag,
    output logic coin_rej_flag
);
    import vend_pkg::*;

    localparam int CW = $clog2(COIN_DLY + 1);

    logic          pending_q, pending_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fn_q, fn_d;
    logic          rej_q, rej_d;
    logic          decide;

    always_comb begin
        coin_take = coin_en && !pending_q && coin_sig;
        decide    = pending_q && (cnt_q == CW'(1));
        pending_d = pending_q;
        cnt_d     = cnt_q;
        fn_d      = 1'b0;
        rej_d     = 1'b0;
        if (coin_take) begin
            pending_d = 1'b1;
            cnt_d     = CW'(COIN_DLY - 1);
        end else if (decide) begin
            pending_d = 1'b0;
            cnt_d     = '0;
            fn_d      = !coin_ov_flag;
            rej_d     = coin_ov_flag;
        end else if (pending_q) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
            fn_q      <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            fn_q      <= fn_d;
            rej_q     <= rej_d;
        end
    end

    assign pending       = pending_q;
    assign coin_fn_flag  = fn_q;
    assign coin_rej_flag = rej_q;

endmodule

// File: rtl/vend_ctrl_fsm.sv
// Central vending-machine controller. Optional auto refund after dispensing
// is enabled by defining VEND_AUTO_CHANGE_EN.
module vend_ctrl_fsm #(
    parameter int COIN_DLY = 2,
    parameter int DISP_CYC = 50_000_000,
    parameter int WARN_CYC = 25_000_000,
    parameter int CHG_CYC  = 50_000_000
) (
    input logic            clk,
    input logic            rst_n,
    vend_ctrl_fsm_if.slave bus
);
    import vend_pkg::*;

    localparam int MAX_DW  = (DISP_CYC > WARN_CYC) ? DISP_CYC : WARN_CYC;
    localparam int MAX_CYC = (MAX_DW > CHG_CYC) ? MAX_DW : CHG_CYC;
    localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    val_t          chg_q, chg_d;
    logic          ready_q;

    logic coin_en, coin_pending, coin_take, coin_busy, timer_done;

    // ready_q keeps every output low in the cycles that follow a reset edge.
    assign coin_en    = ready_q && coin_state(state_q);
    assign coin_busy  = coin_pending || coin_take;
    assign timer_done = (timer_q == '0);

    vend_coin_accept #(.COIN_DLY(COIN_DLY)) u_coin (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_sig      (bus.coin_sig),
        .coin_en       (coin_en),
        .coin_ov_flag  (bus.coin_ov_flag),
        .pending       (coin_pending),
        .coin_take     (coin_take),
        .coin_fn_flag  (bus.coin_fn_flag),
        .coin_rej_flag (bus.coin_rej_flag)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_done ? '0 : timer_q - TW'(1);
        chg_d   = chg_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.select_flag) begin
                    state_d = ST_SELECT;
                end else if (bus.charge_flag && !coin_busy) begin
                    state_d = ST_CHARGE;
                    timer_d = TW'(CHG_CYC - 1);
                    chg_d   = bus.coin_val_sum;
                end
            end
            ST_SELECT: begin
                if (bus.cancel_flag) begin
                    state_d = ST_IDLE;
                end else if (bus.sure_flag && (bus.product_number != 4'd0) && !coin_busy) begin
                    state_d = ST_PAY_CHK;
                end
            end
            ST_PAY_CHK: begin
                if (bus.nonenough_flag) begin
                    state_d = ST_WARN;
                    timer_d = TW'(WARN_CYC - 1);
                end else begin
                    state_d = ST_PAY_DO;
                end
            end
            ST_PAY_DO: begin
                state_d = ST_DISP;
                timer_d = TW'(DISP_CYC - 1);
            end
            ST_DISP: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
`ifdef VEND_AUTO_CHANGE_EN
                    if (bus.coin_val_sum != '0) begin
                        state_d = ST_CHARGE;
                        timer_d = TW'(CHG_CYC - 1);
                        chg_d   = bus.coin_val_sum;
                    end
`else
                    chg_d = chg_q;
`endif
                end
            end
            ST_WARN: begin
                if (timer_done) state_d = ST_SELECT;
            end
            ST_CHARGE: begin
                if (timer_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            chg_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            chg_q   <= chg_d;
            ready_q <= 1'b1;
        end
    end

    assign bus.selected_sta_flag = (state_q == ST_SELECT);
    assign bus.coin_sta_flag     = coin_en || coin_pending;
    assign bus.pay_sta_flag      = (state_q == ST_PAY_CHK) || (state_q == ST_PAY_DO);
    assign bus.pay_st_flag       = (state_q == ST_PAY_DO);
    assign bus.charge_st_flag    = (state_q == ST_CHARGE) && (timer_q == TW'(CHG_CYC - 1));
    assign bus.dispense_flag     = (state_q == ST_DISP);
    assign bus.warn_flag         = (state_q == ST_WARN);
    assign bus.charge_busy       = (state_q == ST_CHARGE);
    assign bus.change_val        = chg_q;
    assign bus.state_o           = state_q;

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Testbench for vend_ctrl_fsm: hand-derived vector table for the main flows,
// then random traffic checked cycle by cycle against a behavioural model.
module tb_vend_ctrl_fsm;
    import vend_pkg::*;

    localparam int COIN_DLY = 2;
    localparam int DISP_CYC = 4;
    localparam int WARN_CYC = 3;
    localparam int CHG_CYC  = 5;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_SEL  = 5'b10000;
    localparam logic [4:0] P_SURE = 5'b01000;
    localparam logic [4:0] P_CAN  = 5'b00100;
    localparam logic [4:0] P_COIN = 5'b00010;
    localparam logic [4:0] P_CHG  = 5'b00001;

    localparam logic [9:0] F_SEL   = 10'b10_0000_0000;
    localparam logic [9:0] F_CSTA  = 10'b01_0000_0000;
    localparam logic [9:0] F_CFN   = 10'b00_1000_0000;
    localparam logic [9:0] F_PSTA  = 10'b00_0100_0000;
    localparam logic [9:0] F_PST   = 10'b00_0010_0000;
    localparam logic [9:0] F_CST   = 10'b00_0001_0000;
    localparam logic [9:0] F_DISP  = 10'b00_0000_1000;
    localparam logic [9:0] F_WARN  = 10'b00_0000_0100;
    localparam logic [9:0] F_CREJ  = 10'b00_0000_0010;
    localparam logic [9:0] F_CBUSY = 10'b00_0000_0001;

    typedef struct packed {
        logic        rst_n;
        logic [4:0]  pulses;
        logic        nonenough;
        logic        coin_ov;
        logic [3:0]  product;
        logic [10:0] sum;
    } in_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [9:0]  fl;
        logic [10:0] chg;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } row_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    row_t tab[$];

    vend_ctrl_fsm_if bus();

    vend_ctrl_fsm #(
        .COIN_DLY (COIN_DLY),
        .DISP_CYC (DISP_CYC),
        .WARN_CYC (WARN_CYC),
        .CHG_CYC  (CHG_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase code, cycles left in a timed phase (counting the
    // current one), and the absolute cycle on which a pending coin is decided.
    int          cyc;
    int          m_state;
    int          m_left;
    bit          m_ready;
    int          m_due;
    bit          m_fn;
    bit          m_rej;
    logic [10:0] m_chg;

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_ready = 1'b0;
        m_due   = -1;
        m_fn    = 1'b0;
        m_rej   = 1'b0;
        m_chg   = '0;
    endtask

    task automatic model_step(input in_t s);
        bit pend, sta, take, busy;
        int ns, nl;
        if (!s.rst_n) begin
            model_reset();
        end else begin
            pend  = (m_due >= 0) && (cyc < m_due);
            sta   = (m_ready && (m_state == 0 || m_state == 1)) || pend;
            take  = sta && !pend && s.pulses[1];
            busy  = pend || take;
            m_fn  = (m_due == cyc + 1) && !s.coin_ov;
            m_rej = (m_due == cyc + 1) && s.coin_ov;
            if (take) m_due = cyc + COIN_DLY;
            ns = m_state;
            nl = (m_left > 0) ? m_left - 1 : 0;
            case (m_state)
                0: if (s.pulses[4]) ns = 1;
                   else if (s.pulses[0] && !busy) begin ns = 6; nl = CHG_CYC; m_chg = s.sum; end
                1: if (s.pulses[2]) ns = 0;
                   else if (s.pulses[3] && s.product != 0 && !busy) ns = 2;
                2: if (s.nonenough) begin ns = 5; nl = WARN_CYC; end else ns = 3;
                3: begin ns = 4; nl = DISP_CYC; end
                4: if (m_left == 1) begin
                       ns = 0;
`ifdef VEND_AUTO_CHANGE_EN
                       if (s.sum != 0) begin ns = 6; nl = CHG_CYC; m_chg = s.sum; end
`endif
                   end
                5: if (m_left == 1) ns = 1;
                6: if (m_left == 1) ns = 0;
                default: ns = 0;
            endcase
            m_state = ns;
            m_left  = nl;
            m_ready = 1'b1;
        end
        cyc++;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   pend;
        pend    = (m_due >= 0) && (cyc < m_due);
        e.st    = 3'(m_state);
        e.fl    = '0;
        e.fl[9] = (m_state == 1);
        e.fl[8] = (m_ready && (m_state == 0 || m_state == 1)) || pend;
        e.fl[7] = m_fn;
        e.fl[6] = (m_state == 2) || (m_state == 3);
        e.fl[5] = (m_state == 3);
        e.fl[4] = (m_state == 6) && (m_left == CHG_CYC);
        e.fl[3] = (m_state == 4);
        e.fl[2] = (m_state == 5);
        e.fl[1] = m_rej;
        e.fl[0] = (m_state == 6);
        e.chg   = m_chg;
        return e;
    endfunction

    function automatic row_t r(input bit rst, input logic [4:0] p, input bit ne,
                               input bit ov, input logic [3:0] prod,
                               input logic [10:0] sum, input logic [2:0] st,
                               input logic [9:0] fl, input logic [10:0] chg);
        row_t x;
        x.in.rst_n     = rst;
        x.in.pulses    = p;
        x.in.nonenough = ne;
        x.in.coin_ov   = ov;
        x.in.product   = prod;
        x.in.sum       = sum;
        x.ex.st        = st;
        x.ex.fl        = fl;
        x.ex.chg       = chg;
        return x;
    endfunction

    // Drive one cycle of inputs, advance the model, and move to the next negedge.
    task automatic applyStimulus(input in_t s);
        rst_n              = s.rst_n;
        bus.select_flag    = s.pulses[4];
        bus.sure_flag      = s.pulses[3];
        bus.cancel_flag    = s.pulses[2];
        bus.coin_sig       = s.pulses[1];
        bus.charge_flag    = s.pulses[0];
        bus.nonenough_flag = s.nonenough;
        bus.coin_ov_flag   = s.coin_ov;
        bus.product_number = s.product;
        bus.coin_val_sum   = s.sum;
        model_step(s);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input bit use_tab, input exp_t t);
        exp_t got, m;
        got.st  = bus.state_o;
        got.fl  = {bus.selected_sta_flag, bus.coin_sta_flag, bus.coin_fn_flag,
                   bus.pay_sta_flag, bus.pay_st_flag, bus.charge_st_flag,
                   bus.dispense_flag, bus.warn_flag, bus.coin_rej_flag, bus.charge_busy};
        got.chg = bus.change_val;
        m = model_out();
        checks++;
        if (got !== m) begin
            errors++;
            $display("[TB] FAIL model cycle %0d: got st=%0d fl=%b chg=%0d, want st=%0d fl=%b chg=%0d",
                     cyc, got.st, got.fl, got.chg, m.st, m.fl, m.chg);
        end
        if (use_tab) begin
            checks++;
            if (got !== t) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got st=%0d fl=%b chg=%0d, want st=%0d fl=%b chg=%0d",
                         name, cyc, got.st, got.fl, got.chg, t.st, t.fl, t.chg);
            end
        end
    endtask

    initial begin
        in_t s;
        int  k;
        rst_n = 1'b0;
        s     = '0;
        applyStimulus(s);
        model_reset();
        cyc = 1;

        // reset and purchase with enough money
        tab.push_back(r(0, P_NONE, 0, 0, 0, 0, ST_IDLE,    '0,              0));
        tab.push_back(r(1, P_NONE, 0, 0, 0, 0, ST_IDLE,    F_CSTA,          0));
        tab.push_back(r(1, P_SEL,  0, 0, 0, 0, ST_SELECT,  F_SEL | F_CSTA,  0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  0));
        tab.push_back(r(1, P_SURE, 0, 0, 3, 0, ST_PAY_CHK, F_PSTA,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_PAY_DO,  F_PSTA | F_PST,  0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
        // insufficient funds
        tab.push_back(r(1, P_SEL,  0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  0));
        tab.push_back(r(1, P_SURE, 1, 0, 3, 0, ST_PAY_CHK, F_PSTA,          0));
        tab.push_back(r(1, P_NONE, 1, 0, 3, 0, ST_WARN,    F_WARN,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_WARN,    F_WARN,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_WARN,    F_WARN,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  0));
        // coin accepted, second coin during pending ignored
        tab.push_back(r(1, P_CAN,  0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
        tab.push_back(r(1, P_COIN, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
        tab.push_back(r(1, P_COIN, 0, 0, 3, 0, ST_IDLE,    F_CSTA | F_CFN,  0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
        // coin rejected on overflow (1990 + 20)
        tab.push_back(r(1, P_COIN, 0, (11'd1990 + 11'd20 > MAX_BAL), 3, 1990, ST_IDLE, F_CSTA, 0));
        tab.push_back(r(1, P_NONE, 0, (11'd1990 + 11'd20 > MAX_BAL), 3, 1990, ST_IDLE, F_CSTA | F_CREJ, 0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 1990, ST_IDLE, F_CSTA, 0));
        // change-out of 37
        tab.push_back(r(1, P_CHG,  0, 0, 3, 37, ST_CHARGE, F_CST | F_CBUSY, 37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 37, ST_CHARGE, F_CBUSY,         37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 37, ST_CHARGE, F_CBUSY,         37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 37, ST_CHARGE, F_CBUSY,         37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 37, ST_CHARGE, F_CBUSY,         37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 37, ST_IDLE,   F_CSTA,          37));
        // charge ignored while a coin is pending
        tab.push_back(r(1, P_COIN, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          37));
        tab.push_back(r(1, P_CHG,  0, 0, 3, 0, ST_IDLE,    F_CSTA | F_CFN,  37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          37));
        // cancel beats sure; sure blocked by pending coin or empty product
        tab.push_back(r(1, P_SEL,  0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  37));
        tab.push_back(r(1, P_SURE | P_CAN, 0, 0, 3, 0, ST_IDLE, F_CSTA,     37));
        tab.push_back(r(1, P_SEL,  0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  37));
        tab.push_back(r(1, P_COIN, 0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  37));
        tab.push_back(r(1, P_SURE, 0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA | F_CFN, 37));
        tab.push_back(r(1, P_SURE, 0, 0, 0, 0, ST_SELECT,  F_SEL | F_CSTA,  37));
        tab.push_back(r(1, P_COIN, 0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  37));
        tab.push_back(r(1, P_CAN,  0, 0, 3, 0, ST_IDLE,    F_CSTA | F_CFN,  37));
        // reset during dispense
        tab.push_back(r(1, P_SEL,  0, 0, 3, 0, ST_SELECT,  F_SEL | F_CSTA,  37));
        tab.push_back(r(1, P_SURE, 0, 0, 3, 0, ST_PAY_CHK, F_PSTA,          37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_PAY_DO,  F_PSTA | F_PST,  37));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_DISP,    F_DISP,          37));
        tab.push_back(r(0, P_NONE, 0, 0, 3, 0, ST_IDLE,    '0,              0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
        // reset drops a pending coin
        tab.push_back(r(1, P_COIN, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
        tab.push_back(r(0, P_NONE, 0, 0, 3, 0, ST_IDLE,    '0,              0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 0, ST_IDLE,    F_CSTA,          0));
`ifdef VEND_AUTO_CHANGE_EN
        // purchase leaving balance 6 refunds automatically
        tab.push_back(r(1, P_SEL,  0, 0, 3, 6, ST_SELECT,  F_SEL | F_CSTA,  0));
        tab.push_back(r(1, P_SURE, 0, 0, 3, 6, ST_PAY_CHK, F_PSTA,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 6, ST_PAY_DO,  F_PSTA | F_PST,  0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 6, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 6, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 6, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 6, ST_DISP,    F_DISP,          0));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 6, ST_CHARGE,  F_CST | F_CBUSY, 6));
        tab.push_back(r(1, P_NONE, 0, 0, 3, 6, ST_CHARGE,  F_CBUSY,         6));
`endif

        $display("[TB] applying %0d table vectors", tab.size());
        foreach (tab[i]) begin
            applyStimulus(tab[i].in);
            checkOutput($sformatf("row%0d", i), 1'b1, tab[i].ex);
        end

        $display("[TB] random traffic against the model");
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 15));
            case (k)
                0:       s.pulses = P_SEL;
                1, 2:    s.pulses = P_SURE;
                3:       s.pulses = P_CAN;
                4, 5:    s.pulses = P_COIN;
                6:       s.pulses = P_CHG;
                7:       s.pulses = P_SURE | P_CAN;
                8:       s.pulses = P_COIN | P_CHG;
                9:       s.pulses = P_COIN | P_SURE;
                default: s.pulses = P_NONE;
            endcase
            s.rst_n     = ($urandom_range(0, 299) != 0);
            s.nonenough = $urandom_range(0, 1) == 1;
            s.coin_ov   = $urandom_range(0, 3) == 0;
            s.product   = 4'($urandom_range(0, 3));
            s.sum       = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 1999));
            applyStimulus(s);
            checkOutput("random", 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
